cl_to_st_unpacker: RTL and testbench

CL_TO_ST_UNPACKER -- requirements
Module: cl_to_st_unpacker

---
 rtl/cl_st_pkg.sv | 31 +++
 rtl/cl_to_st_unpacker.sv | 170 +++++++++++++++++
 tb/tb_cl_to_st_unpacker.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_st_pkg.sv
// cl_st_pkg: head field positions and FSM state encoding
// shared by the cache-line to symbol-stream unpacker.
package cl_st_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  // LEN sits at the bottom of the head.
  localparam int unsigned HEAD_LEN_LSB = 0;

  // Flags are counted down from the top of the head.
  localparam int unsigned HEAD_EOF_OFS = 1;
  localparam int unsigned HEAD_SOF_OFS = 2;

  function automatic int unsigned head_sof_bit(
    input int unsigned head_w
  );
    return head_w - HEAD_SOF_OFS;
  endfunction

  function automatic int unsigned head_eof_bit(
    input int unsigned head_w
  );
    return head_w - HEAD_EOF_OFS;
  endfunction

endpackage

// File: rtl/cl_to_st_unpacker.sv
// cl_to_st_unpacker: reads cache lines from a FIFO and
// streams their payload as ST-bit symbols, LSB first.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   ff_empty      : FIFO empty
//   ff_rdreq      : FIFO read request (q valid next cycle)
//   ff_q          : FIFO data, head in [CL_HEAD-1:0]
//   source_ready  : downstream ready
//   source_data   : current symbol
//   source_valid  : symbol valid
//   source_sop    : first symbol of a frame
//   source_eop    : last symbol of a frame
//   ff_rd_finish  : pulse after eop when FIFO drained
//   err_len       : pulse on bad LEN or nested SOF
module cl_to_st_unpacker
  import cl_st_pkg::*;
#(
  parameter int CL      = 512,
  parameter int CL_HEAD = 16,
  parameter int ST      = 12,
  parameter int W_LEN   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ff_empty,
  output logic          ff_rdreq,
  input  logic [CL-1:0] ff_q,
  input  logic          source_ready,
  output logic [ST-1:0] source_data,
  output logic          source_valid,
  output logic          source_sop,
  output logic          source_eop,
  output logic          ff_rd_finish,
  output logic          err_len
);

  localparam int CL_PAYLOAD = CL - CL_HEAD;
  localparam int MAX_SYM    = CL_PAYLOAD / ST;
  localparam int SOF_BIT    = int'(head_sof_bit(CL_HEAD));
  localparam int EOF_BIT    = int'(head_eof_bit(CL_HEAD));

  localparam logic [W_LEN-1:0] MAX_LEN = W_LEN'(MAX_SYM);
  localparam logic [W_LEN-1:0] ONE     = W_LEN'(1);

  if (MAX_SYM >= 2**W_LEN || ST > CL_PAYLOAD ||
      CL_HEAD < W_LEN + 2) begin : g_bad_params
    $error("cl_to_st_unpacker: bad parameters");
  end

  // Head bits between LEN and the flags carry nothing.
  if (CL_HEAD > W_LEN + 2) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^ff_q[CL_HEAD-3:W_LEN];
  end

  state_t state_q, state_d;

  logic [CL_PAYLOAD-1:0] sreg_q;
  logic [W_LEN-1:0]      cnt_q;
  logic                  sof_q;
  logic                  eof_q;
  logic                  first_q;
  logic                  open_q;
  logic                  fin_q;

  logic [W_LEN-1:0] head_len;
  logic [W_LEN-1:0] len_clamp;
  logic             head_sof;
  logic             head_eof;
  logic             len_zero;
  logic             len_over;
  logic             xfer;
  logic             last;
  logic             rdreq;
  logic             err;

  assign head_len  = ff_q[HEAD_LEN_LSB +: W_LEN];
  assign head_sof  = ff_q[SOF_BIT];
  assign head_eof  = ff_q[EOF_BIT];
  assign len_zero  = (head_len == '0);
  assign len_over  = (head_len > MAX_LEN);
  assign len_clamp = len_over ? MAX_LEN : head_len;

  assign source_valid = (state_q == S_SHIFT);
  assign xfer         = source_valid & source_ready;
  assign last         = (cnt_q == ONE);

  assign source_data  = sreg_q[ST-1:0];
  assign source_sop   = source_valid & first_q & sof_q;
  assign source_eop   = source_valid & eof_q & last;
  assign ff_rd_finish = fin_q;

  // rst also masks the decode-driven pulses so nothing
  // escapes while the state register is being cleared.
  assign ff_rdreq = rdreq & ~rst;
  assign err_len  = err & ~rst;

  always_comb begin
    state_d = state_q;
    rdreq   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!ff_empty) begin
          rdreq   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        err = len_zero | len_over |
              (head_sof & open_q);
        // An empty line is dropped and the next
        // one fetched straight away.
        if (len_zero) begin
          rdreq   = ~ff_empty;
          state_d = ff_empty ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (xfer && last) begin
          rdreq   = ~ff_empty;
          state_d = ff_empty ? S_IDLE : S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      first_q <= 1'b0;
      open_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= xfer & source_eop & ff_empty;
      if (state_q == S_LOAD) begin
        sreg_q  <= ff_q[CL-1:CL_HEAD];
        cnt_q   <= len_clamp;
        sof_q   <= head_sof & ~len_zero;
        eof_q   <= head_eof & ~len_zero;
        first_q <= 1'b1;
        if (!len_zero && head_sof) begin
          open_q <= 1'b1;
        end
      end else if (xfer) begin
        sreg_q  <= sreg_q >> ST;
        cnt_q   <= cnt_q - ONE;
        first_q <= 1'b0;
        if (source_eop) begin
          open_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cl_to_st_unpacker.sv
// tb_cl_to_st_unpacker: table, hand-written and random
// checks of the cache-line to symbol-stream unpacker.
module tb_cl_to_st_unpacker;

  localparam int CL      = 512;
  localparam int CL_HEAD = 16;
  localparam int ST      = 12;
  localparam int W_LEN   = 10;
  localparam int MAX_SYM = (CL - CL_HEAD) / ST;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ff_empty;
  logic          ff_rdreq;
  logic [CL-1:0] ff_q = '0;
  logic          source_ready = 1'b1;
  logic [ST-1:0] source_data;
  logic          source_valid;
  logic          source_sop;
  logic          source_eop;
  logic          ff_rd_finish;
  logic          err_len;

  cl_to_st_unpacker #(
    .CL(CL), .CL_HEAD(CL_HEAD),
    .ST(ST), .W_LEN(W_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ff_empty(ff_empty),
    .ff_rdreq(ff_rdreq),
    .ff_q(ff_q),
    .source_ready(source_ready),
    .source_data(source_data),
    .source_valid(source_valid),
    .source_sop(source_sop),
    .source_eop(source_eop),
    .ff_rd_finish(ff_rd_finish),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  // FIFO model: lines written by the test, popped on rdreq.
  logic [CL-1:0] mem [0:1023];
  int wr_n = 0;
  int rd_n = 0;
  int bad_rd = 0;

  assign ff_empty = (rd_n == wr_n);

  always @(posedge clk) begin
    if (ff_rdreq) begin
      if (rd_n == wr_n) begin
        bad_rd <= bad_rd + 1;
      end else begin
        ff_q <= mem[rd_n];
        rd_n <= rd_n + 1;
      end
    end
  end

  // Ready pattern: 0 always, 1 toggle, 2 random.
  int rdy_mode = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       source_ready = ~source_ready;
      2:       source_ready = ($urandom_range(0, 9) < 7);
      default: source_ready = 1'b1;
    endcase
  end

  // Monitor: records every valid cycle.
  typedef struct packed {
    logic [31:0]   cyc;
    logic [ST-1:0] d;
    logic          sop;
    logic          eop;
    logic          rdy;
  } samp_t;

  samp_t samp [0:16383];
  int samp_n = 0;
  int xfer_n = 0;
  int err_seen = 0;
  int fin_seen = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (source_valid) begin
        samp[samp_n] <= {cyc, source_data, source_sop,
                         source_eop, source_ready};
        samp_n <= samp_n + 1;
        if (source_ready) xfer_n <= xfer_n + 1;
      end
      if (err_len)      err_seen <= err_seen + 1;
      if (ff_rd_finish) fin_seen <= fin_seen + 1;
    end
  end

  int vec_n = 0;
  int miss_n = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  // Expected stream for the current segment.
  logic [ST-1:0] exp_d [$];
  bit            exp_sop [$];
  bit            exp_eop [$];
  logic [ST-1:0] last_pay [0:63];

  task automatic push_line(input int len,
                           input bit sof,
                           input bit eof);
    logic [CL-1:0] ln;
    logic [ST-1:0] sym;
    for (int w = 0; w < CL / 32; w++)
      ln[w*32 +: 32] = $urandom;
    for (int k = 0; k < MAX_SYM; k++) begin
      sym = ST'($urandom);
      last_pay[k] = sym;
      ln[CL_HEAD + k*ST +: ST] = sym;
    end
    ln[W_LEN-1:0]   = W_LEN'(len);
    ln[CL_HEAD-2]   = sof;
    ln[CL_HEAD-1]   = eof;
    mem[wr_n] = ln;
    wr_n = wr_n + 1;
  endtask

  task automatic exp_add(input int n,
                         input bit sop,
                         input bit eop);
    for (int k = 0; k < n; k++) begin
      exp_d.push_back(last_pay[k]);
      exp_sop.push_back(sop && k == 0);
      exp_eop.push_back(eop && k == n - 1);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, source_valid, 0);
    chk({nm, "_data"}, source_data, 0);
    chk({nm, "_sop"}, source_sop, 0);
    chk({nm, "_eop"}, source_eop, 0);
    chk({nm, "_rdreq"}, ff_rdreq, 0);
    chk({nm, "_finish"}, ff_rd_finish, 0);
    chk({nm, "_err"}, err_len, 0);
  endtask

  task automatic finish_seg(input string nm,
                            input int s0, input int x0,
                            input int e0, input int f0,
                            input int exp_err,
                            input int exp_fin,
                            input bit gap_chk);
    int b;
    int na;
    int gap;
    samp_t s;
    samp_t p;
    logic [ST-1:0] ad [$];
    bit asop [$];
    bit aeop [$];
    int acyc [$];
    b = 0;
    while ((((xfer_n - x0) < exp_d.size()) ||
            (rd_n != wr_n)) && (b < 20000)) begin
      @(posedge clk); #1;
      b++;
    end
    chk({nm, "_timeout"}, (b >= 20000), 0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    for (int i = s0; i < samp_n; i++) begin
      s = samp[i];
      if (s.rdy) begin
        ad.push_back(s.d);
        asop.push_back(s.sop);
        aeop.push_back(s.eop);
        acyc.push_back(int'(s.cyc));
      end else if (i + 1 < samp_n) begin
        p = samp[i+1];
        chk({nm, "_hold_cyc"}, p.cyc, s.cyc + 1);
        chk({nm, "_hold_data"}, p.d, s.d);
        chk({nm, "_hold_sop"}, p.sop, s.sop);
        chk({nm, "_hold_eop"}, p.eop, s.eop);
      end
    end
    na = ad.size();
    chk({nm, "_count"}, na, exp_d.size());
    for (int k = 0; k < na && k < exp_d.size(); k++) begin
      chk($sformatf("%s_sym%0d", nm, k), ad[k], exp_d[k]);
      chk($sformatf("%s_sop%0d", nm, k), asop[k],
          exp_sop[k]);
      chk($sformatf("%s_eop%0d", nm, k), aeop[k],
          exp_eop[k]);
    end
    if (gap_chk) begin
      for (int k = 1; k < na; k++) begin
        gap = acyc[k] - acyc[k-1] - 1;
        vec_n++;
        if (gap > 2) begin
          miss_n++;
          $display("FAIL %s_gap%0d: got %0d, expected <=2",
                   nm, k, gap);
        end
      end
    end
    chk({nm, "_err_len"}, err_seen - e0, exp_err);
    chk({nm, "_rd_finish"}, fin_seen - f0, exp_fin);
    exp_d.delete();
    exp_sop.delete();
    exp_eop.delete();
  endtask

  typedef struct {
    int len;
    bit sof;
    bit eof;
    int n;
    int err;
    bit sop;
    bit eop;
    int fin;
  } vec_t;

  vec_t tbl [9];

  int s0, x0, e0, f0;
  int b;
  int r, len, n;
  bit sof, eof;
  int m_open, m_err, last_len;
  bit last_eof;

  task automatic mark();
    s0 = samp_n;
    x0 = xfer_n;
    e0 = err_seen;
    f0 = fin_seen;
  endtask

  initial begin
    // len sof eof | syms err sop eop fin
    tbl[0] = '{3,    1, 1,  3,       0, 1, 1, 1};
    tbl[1] = '{1,    1, 1,  1,       0, 1, 1, 1};
    tbl[2] = '{41,   1, 1,  41,      0, 1, 1, 1};
    tbl[3] = '{60,   1, 1,  41,      1, 1, 1, 1};
    tbl[4] = '{1023, 0, 0,  41,      1, 0, 0, 0};
    tbl[5] = '{0,    1, 1,  0,       1, 0, 0, 0};
    tbl[6] = '{5,    1, 0,  5,       0, 1, 0, 0};
    tbl[7] = '{2,    1, 1,  2,       1, 1, 1, 1};
    tbl[8] = '{7,    0, 1,  7,       0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) begin
      mark();
      push_line(tbl[t].len, tbl[t].sof, tbl[t].eof);
      exp_add(tbl[t].n, tbl[t].sop, tbl[t].eop);
      finish_seg($sformatf("tbl%0d", t), s0, x0, e0, f0,
                 tbl[t].err, tbl[t].fin, 1'b1);
    end

    // Three-line frame, back to back.
    mark();
    push_line(41, 1, 0);
    exp_add(41, 1, 0);
    push_line(41, 0, 0);
    exp_add(41, 0, 0);
    push_line(5, 0, 1);
    exp_add(5, 0, 1);
    finish_seg("frame3", s0, x0, e0, f0, 0, 1, 1'b1);

    // Alternating ready on a short line.
    rdy_mode = 1;
    mark();
    push_line(4, 1, 1);
    exp_add(4, 1, 1);
    finish_seg("toggle", s0, x0, e0, f0, 0, 1, 1'b0);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Empty line then a two-symbol frame.
    mark();
    push_line(0, 1, 1);
    push_line(2, 1, 1);
    exp_add(2, 1, 1);
    finish_seg("len0", s0, x0, e0, f0, 1, 1, 1'b1);

    // Reset in the middle of an open frame.
    mark();
    push_line(20, 1, 0);
    b = 0;
    while ((xfer_n - x0) < 5 && b < 1000) begin
      @(posedge clk); #1;
      b++;
    end
    chk("rst_wait_timeout", (b >= 1000), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("rst_mid");
    rst = 1'b0;
    exp_add(5, 1, 0);
    finish_seg("rst_cut", s0, x0, e0, f0, 0, 0, 1'b0);
    mark();
    push_line(3, 1, 1);
    exp_add(3, 1, 1);
    finish_seg("rst_next", s0, x0, e0, f0, 0, 1, 1'b1);

    // Random lines, random ready, reference model.
    rdy_mode = 2;
    mark();
    m_open = 0;
    m_err = 0;
    last_len = 0;
    last_eof = 0;
    for (int j = 0; j < 60; j++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        len = 0;
      else if (r == 1)
        len = $urandom_range(MAX_SYM + 1, 1023);
      else
        len = $urandom_range(1, MAX_SYM);
      sof = ($urandom_range(0, 2) == 0);
      eof = ($urandom_range(0, 2) == 0);
      push_line(len, sof, eof);
      if (len == 0) begin
        m_err++;
      end else begin
        n = (len > MAX_SYM) ? MAX_SYM : len;
        if (len > MAX_SYM || (sof && m_open != 0))
          m_err++;
        exp_add(n, sof, eof);
        if (sof) m_open = 1;
        if (eof) m_open = 0;
      end
      last_len = len;
      last_eof = eof;
    end
    finish_seg("rand", s0, x0, e0, f0, m_err,
               (last_len > 0 && last_eof) ? 1 : 0, 1'b0);
    rdy_mode = 0;

    chk("rdreq_when_empty", bad_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, miss_n);
    $finish;
  end

endmodule
